// File: rtl/u_lsu_if.sv
// Data-memory bus between the load/store unit (master) and the memory (slave).
// Single outstanding transaction: req held until gnt, read data returned with rvld.
interface u_lsu_if #(
  parameter int unsigned AW = 32
);
  logic          mem_req;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_gnt;
  logic          mem_rvld;
  logic [31:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvld, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_gnt, mem_rvld, mem_rdata
  );
endinterface

// File: rtl/u_lsu.sv
// Load/store unit: takes one byte-masked request from the execute stage,
// lane-aligns it, runs one req/gnt (+rvld for loads) bus transaction and
// returns formatted load data or a completion pulse. Misaligned/illegal
// accesses and bus timeouts complete with a one-cycle lsu_err pulse.
module u_lsu #(
  parameter int unsigned AW      = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lsu_a,
  input  logic [3:0]  lsu_we,
  input  logic [31:0] lsu_wd,
  input  logic [3:0]  lsu_re,
  input  logic        lsu_sx,
  output logic        lsu_vld,
  output logic [31:0] lsu_rd,
  output logic        lsu_err,
  output logic        lsu_busy,
  u_lsu_if.master     mem
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t state_q, state_d;

  // captured request
  logic          we_q;
  logic [3:0]    mask_q;
  logic [1:0]    off_q;
  logic          sx_q;
  logic [AW-1:2] addr_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;

  // timeout counter for REQ/WAIT
  logic [7:0]    cnt_q;
  logic          tmo_hit;

  // request decode
  logic          req_any;
  logic          req_store;
  logic [3:0]    req_mask;
  logic [1:0]    req_off;
  logic          req_bad;

  // FSM strobes
  logic          capture;
  logic          cnt_clr;
  logic          cnt_inc;
  logic          fin_vld;
  logic          fin_load;
  logic          fin_err;

  // load formatting
  logic [31:0]   rd_shift;
  logic [31:0]   rd_fmt;

  assign tmo_hit  = (cnt_q == 8'(TIMEOUT - 1));
  assign lsu_busy = (state_q != IDLE);

  assign mem.mem_req   = (state_q == REQ);
  assign mem.mem_we    = we_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_addr  = {addr_q, 2'b00};
  assign mem.mem_wdata = wdata_q;

  // Decode the incoming request: a store wins over a load; illegal masks
  // are folded into the misalignment check.
  always_comb begin
    req_any   = (|lsu_we) || (|lsu_re);
    req_store = |lsu_we;
    req_mask  = req_store ? lsu_we : lsu_re;
    req_off   = lsu_a[1:0];
    case (req_mask)
      4'b0001: req_bad = 1'b0;
      4'b0011: req_bad = req_off[0];
      4'b1111: req_bad = |req_off;
      default: req_bad = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control strobes.
  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    fin_vld  = 1'b0;
    fin_load = 1'b0;
    fin_err  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_any) begin
          if (req_bad) begin
            fin_err = 1'b1;
          end else begin
            capture = 1'b1;
            cnt_clr = 1'b1;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (mem.mem_gnt) begin
          cnt_clr = 1'b1;
          if (we_q) begin
            fin_vld = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT;
          end
        end else if (tmo_hit) begin
          fin_err = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      WAIT: begin
        if (mem.mem_rvld) begin
          fin_vld  = 1'b1;
          fin_load = 1'b1;
          state_d  = IDLE;
        end else if (tmo_hit) begin
          fin_err = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Right-align the addressed lanes and extend to 32 bits.
  always_comb begin
    rd_shift = mem.mem_rdata >> {off_q, 3'b000};
    case (mask_q)
      4'b0001: rd_fmt = {{24{sx_q & rd_shift[7]}}, rd_shift[7:0]};
      4'b0011: rd_fmt = {{16{sx_q & rd_shift[15]}}, rd_shift[15:0]};
      default: rd_fmt = rd_shift;
    endcase
  end

  // Request capture with lane shifting done up front so the bus fields
  // stay stable for the whole REQ phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      mask_q  <= '0;
      off_q   <= '0;
      sx_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else if (capture) begin
      we_q    <= req_store;
      mask_q  <= req_mask;
      off_q   <= req_off;
      sx_q    <= lsu_sx;
      addr_q  <= lsu_a[AW-1:2];
      be_q    <= req_mask << req_off;
      wdata_q <= lsu_wd << {req_off, 3'b000};
    end
  end

  // Timeout counter: cleared on entry to REQ/WAIT, counts while waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (cnt_inc) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  // Registered completion outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lsu_vld <= 1'b0;
      lsu_err <= 1'b0;
      lsu_rd  <= '0;
    end else begin
      lsu_vld <= fin_vld;
      lsu_err <= fin_err;
      lsu_rd  <= fin_load ? rd_fmt : '0;
    end
  end

endmodule
